// File: rtl/piso_bidir_tx_if.sv
// Word-in / bit-out link bundle between the word producer, the serialiser and the serial wire.
// The master side offers words; the slave side (the transmitter) drives ready and the serial outputs.
interface piso_bidir_tx_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             dir;
    logic             sout;
    logic             sout_valid;
    logic             last;
    logic             busy;

    modport master (
        output load_data, load_valid, dir,
        input  load_ready, sout, sout_valid, last, busy
    );

    modport slave (
        input  load_data, load_valid, dir,
        output load_ready, sout, sout_valid, last, busy
    );
endinterface

// File: rtl/piso_bidir_tx.sv
// Serialises a WIDTH-bit word MSB- or LSB-first; bit 0 appears one cycle after acceptance.
// Stalls the producer via load_ready (high only when idle or on the last bit); no buffering.
module piso_bidir_tx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    piso_bidir_tx_if.slave   link
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt, shifted;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             dir_q, dir_nxt;
    logic             sout_q, sout_nxt;
    logic             last_q, last_nxt;
    logic             ready;
    logic             accept;

    // Ready on the last bit lets the next frame follow with no gap cycle.
    assign ready  = rst_n & ((state == IDLE) | ((state == SHIFT) & last_q));
    assign accept = link.load_valid & ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sreg   <= '0;
            cnt    <= '0;
            dir_q  <= 1'b0;
            sout_q <= 1'b0;
            last_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            sreg   <= sreg_nxt;
            cnt    <= cnt_nxt;
            dir_q  <= dir_nxt;
            sout_q <= sout_nxt;
            last_q <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = SHIFT;
        end else if ((state == SHIFT) && last_q) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        sreg_nxt = sreg;
        cnt_nxt  = cnt;
        dir_nxt  = dir_q;
        sout_nxt = 1'b0;
        last_nxt = 1'b0;
        // The bit to present next always sits at the leading end after one shift.
        shifted  = dir_q ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
        if (accept) begin
            sreg_nxt = link.load_data;
            dir_nxt  = link.dir;
            cnt_nxt  = '0;
            sout_nxt = link.dir ? link.load_data[WIDTH-1] : link.load_data[0];
        end else if ((state == SHIFT) && !last_q) begin
            sreg_nxt = shifted;
            cnt_nxt  = cnt + CW'(1);
            sout_nxt = dir_q ? shifted[WIDTH-1] : shifted[0];
            last_nxt = (cnt == CW'(WIDTH - 2));
        end
    end

    assign link.load_ready = ready;
    assign link.sout       = sout_q;
    assign link.sout_valid = (state == SHIFT);
    assign link.last       = last_q;
    assign link.busy       = (state == SHIFT);
endmodule

// File: tb/tb_piso_bidir_tx.sv
// Directed bench for piso_bidir_tx: expected bits are queued at each accepted word and
// compared as they appear on the serial side, alongside a behavioural receiver.
module tb_piso_bidir_tx;
    localparam int W = 4;

    typedef struct packed {
        logic         b;
        logic         l;
        logic         d;
        logic [W-1:0] word;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    piso_bidir_tx_if #(.WIDTH(W)) bus ();
    piso_bidir_tx #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .link(bus));

    exp_t         sb[$];
    logic [W-1:0] rx;
    int           errors = 0;
    int           checks = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_word(input logic [W-1:0] w, input logic d);
        for (int k = 0; k < W; k++) begin
            exp_t e;
            e.b    = d ? w[W-1-k] : w[k];
            e.l    = (k == W - 1);
            e.d    = d;
            e.word = w;
            sb.push_back(e);
        end
    endtask

    // Advance one clock and check the cycle that follows the edge.
    task automatic tick();
        logic exp_valid;
        exp_t e;
        @(posedge clk);
        #1;
        exp_valid = (sb.size() != 0);
        chk("sout_valid", W'(bus.sout_valid), W'(exp_valid));
        chk("busy", W'(bus.busy), W'(exp_valid));
        if (exp_valid) begin
            e = sb.pop_front();
            chk("sout", W'(bus.sout), W'(e.b));
            chk("last", W'(bus.last), W'(e.l));
            rx = e.d ? {rx[W-2:0], bus.sout} : {bus.sout, rx[W-1:1]};
            if (e.l) chk("rx_word", rx, e.word);
        end else begin
            chk("idle_sout", W'(bus.sout), W'(0));
            chk("idle_last", W'(bus.last), W'(0));
        end
    endtask

    task automatic send(input logic [W-1:0] w, input logic d);
        bus.load_data  = w;
        bus.dir        = d;
        bus.load_valid = 1'b1;
        chk("ready_before_send", W'(bus.load_ready), W'(1));
        push_word(w, d);
        tick();
        bus.load_valid = 1'b0;
    endtask

    task automatic frame(input logic [W-1:0] w, input logic d);
        send(w, d);
        chk("ready_bit0", W'(bus.load_ready), W'(0));
        tick();
        tick();
        tick();
        chk("ready_last", W'(bus.load_ready), W'(1));
        tick();
        chk("ready_idle", W'(bus.load_ready), W'(1));
    endtask

    initial begin
        rx             = '0;
        bus.load_data  = 4'hF;
        bus.dir        = 1'b1;
        bus.load_valid = 1'b1;

        // Reset held with a word offered: nothing may be accepted.
        #12;
        chk("rst_sout", W'(bus.sout), W'(0));
        chk("rst_valid", W'(bus.sout_valid), W'(0));
        chk("rst_last", W'(bus.last), W'(0));
        chk("rst_busy", W'(bus.busy), W'(0));
        chk("rst_ready", W'(bus.load_ready), W'(0));
        tick();
        tick();
        chk("rst_ready_held", W'(bus.load_ready), W'(0));
        bus.load_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("ready_after_release", W'(bus.load_ready), W'(1));
        tick();

        // MSB first, then LSB first.
        frame(4'b1011, 1'b1);
        frame(4'b1011, 1'b0);

        // Back-to-back with load_valid held high.
        bus.load_data  = 4'hA;
        bus.dir        = 1'b1;
        bus.load_valid = 1'b1;
        chk("b2b_ready_c0", W'(bus.load_ready), W'(1));
        push_word(4'hA, 1'b1);
        tick();
        chk("b2b_ready_c1", W'(bus.load_ready), W'(0));
        tick();
        chk("b2b_ready_c2", W'(bus.load_ready), W'(0));
        tick();
        chk("b2b_ready_c3", W'(bus.load_ready), W'(0));
        tick();
        chk("b2b_ready_c4", W'(bus.load_ready), W'(1));
        bus.load_data = 4'h5;
        push_word(4'h5, 1'b1);
        tick();
        chk("b2b_ready_c5", W'(bus.load_ready), W'(0));
        bus.load_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();

        // Mid-frame dir toggle and load_valid pulse are ignored.
        send(4'b1100, 1'b1);
        tick();
        bus.dir        = 1'b0;
        bus.load_data  = 4'hF;
        bus.load_valid = 1'b1;
        chk("midframe_ready", W'(bus.load_ready), W'(0));
        tick();
        bus.load_valid = 1'b0;
        bus.dir        = 1'b1;
        tick();
        tick();

        // Reset during the third bit aborts the frame at once.
        send(4'b1011, 1'b1);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_sout", W'(bus.sout), W'(0));
        chk("abort_valid", W'(bus.sout_valid), W'(0));
        chk("abort_last", W'(bus.last), W'(0));
        chk("abort_busy", W'(bus.busy), W'(0));
        chk("abort_ready", W'(bus.load_ready), W'(0));
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
        frame(4'b0110, 1'b1);

        chk("sb_drained", W'(sb.size()), W'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/piso_bidir_tx.md
# piso_bidir_tx

Parallel-in, serial-out transmitter that feeds the bidirectional serial-in shift register. A WIDTH-bit word is accepted through a valid/ready handshake. It is then shifted out one bit per clock, MSB-first or LSB-first, so that a receiver clocked alongside it with the same `dir` reconstructs the word after WIDTH cycles. It sits on the transmit side of the on-chip serial link, between the word-level producer and the serial wire.

## Interface

**Parameters**
- `WIDTH`, default 4: word length in bits, must be ≥ 2. The bit counter is `$clog2(WIDTH)` bits wide.

**Ports**
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `load_data` input WIDTH: parallel word to transmit.
- `load_valid` input 1: producer offers `load_data`/`dir`.
- `load_ready` output 1: transmitter can accept a word this cycle.
- `dir` input 1: bit order, sampled only at acceptance. 1 = MSB first, 0 = LSB first.
- `sout` output 1: serial data bit.
- `sout_valid` output 1: `sout` carries a frame bit this cycle.
- `last` output 1: final bit of the current frame.
- `busy` output 1: a frame is in progress.

## Operation

**States**
- IDLE: `busy`=0, `sout_valid`=0.
- SHIFT: `busy`=1, `sout_valid`=1.

**Handshake**
- `load_ready` = `rst_n` & (IDLE | (SHIFT & `last`)). It is combinational from registered state and forced 0 while reset is asserted.
- A word is accepted on a rising edge where `load_valid` & `load_ready`.
- `load_valid` in SHIFT with `last`=0 is ignored. No buffering.

**Acceptance edge**
- Shift register ← `load_data`.
- Direction register ← `dir`.
- Counter ← 0.
- State → SHIFT.

**Registered outputs after acceptance**
- Bit k, for k = 0..WIDTH-1, appears on `sout` in the k-th cycle after acceptance.
- If `dir`=1, bit k is `load_data[WIDTH-1-k]`.
- If `dir`=0, bit k is `load_data[k]`.
- `last`=1 exactly when k = WIDTH-1.

**Frame end**
- On the edge ending the `last` cycle with no new acceptance: state → IDLE, and `sout`, `sout_valid`, `last` → 0.
- On that edge with a new acceptance: the next frame's bit 0 appears in the following cycle. There is no gap cycle.

**Direction**
- `dir` changes mid-frame have no effect. Only the captured direction register is used.

**Reset**
- Asynchronous: `sout`=0, `sout_valid`=0, `last`=0, `busy`=0, counter=0, shift register=0, state=IDLE.
- Reset asserted mid-frame aborts the frame immediately. No partial completion after release.

## Timing

- Latency is one cycle from the acceptance edge to bit 0 on `sout`.
- A frame occupies exactly WIDTH consecutive `sout_valid` cycles.
- Sustained throughput is one word per WIDTH cycles.
- `sout`, `sout_valid`, `last` and `busy` are all registered, with no combinational path from inputs.
- `load_ready` is the only combinational output and depends on state only, not on `load_valid`.
- The receiver samples `sout` on the rising edge at the end of each `sout_valid` cycle. After the edge ending the `last` cycle, its parallel output equals the transmitted word when both ends use the same `dir`.
- The first rising edge after `rst_n` deasserts sees `load_ready`=1 and may accept a word.

## Test plan

1. **Reset:** hold `rst_n`=0 with `load_valid`=1 → `sout`/`sout_valid`/`last`/`busy`/`load_ready` all 0 and no acceptance. Release → `load_ready`=1, outputs stay 0.
2. **MSB first:** `load_data`=4'b1011, `dir`=1 → `sout` = 1,0,1,1 on cycles 1–4, `last` only on cycle 4. A receiver with `dir`=1 holds 4'b1011 after cycle 4, then `sout_valid`=0.
3. **LSB first:** `load_data`=4'b1011, `dir`=0 → `sout` = 1,1,0,1, and a receiver with `dir`=0 holds 4'b1011.
4. **Back-to-back:** `load_valid` held high with 4'hA then 4'h5, `dir`=1 → 8 contiguous valid bits 1,0,1,0,0,1,0,1, `last` on bits 4 and 8. `load_ready`=1 in cycle 0 and cycle 4 only.
5. **Ignored inputs mid-frame:** load 4'b1100 with `dir`=1, then toggle `dir` and pulse `load_valid` with 4'hF on cycle 2 → output is still 1,1,0,0 and 4'hF is not accepted.
6. **Reset mid-frame:** assert `rst_n`=0 after 2 bits of 4'b1011 → outputs 0 immediately. After release, load 4'b0110 with `dir`=1 → clean 0,1,1,0 frame.
